// File: rtl/byte_mem_pkg.sv
// Shared types and helpers for the byte-serializing memory initiator.
// Holds the FSM/op enums and the next-enabled-byte search.
package byte_mem_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE
    } bm_state_e;

    typedef enum logic {
        READ,
        WRITE
    } bm_op_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } bm_next_t;

    // Lowest enabled byte lane at or above start; start may be 4 (nothing left).
    function automatic bm_next_t next_enabled(input logic [BYTES_PER_WORD-1:0] en,
                                              input logic [2:0]                start);
        bm_next_t r;
        r = '{valid: 1'b0, idx: 2'd0};
        for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
            if (en[i] && (3'(i) >= start)) begin
                r.valid = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_mem_initiator_if.sv
// Core-side word port plus byte-wide memory port of the initiator.
// master = the initiator itself, slave = core stub / byte memory responder.
interface byte_mem_initiator_if;
    import byte_mem_pkg::*;

    logic                      req_read;
    logic                      req_write;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic [BYTES_PER_WORD-1:0] req_wmask;
    logic                      req_ready;
    logic                      rsp_valid;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;

    logic                      mem_read;
    logic                      mem_write;
    logic [31:0]               mem_addr;
    logic [7:0]                mem_wdata;
    logic [7:0]                mem_rdata;
    logic                      mem_resp;

    modport master (
        input  req_read, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output req_read, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/bm_wait_timer.sv
// Saturating wait counter that flags when a byte strobe has waited TIMEOUT cycles.
module bm_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(TIMEOUT));

endmodule

// File: rtl/byte_mem_initiator.sv
// Serializes 32-bit word requests into strobe/resp byte accesses and
// reassembles read bytes into a word, with a per-byte timeout abort.
module byte_mem_initiator
    import byte_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    byte_mem_initiator_if.master bus
);

    bm_state_e                 state, state_n;
    bm_op_e                    op_q, op_n;
    logic [31:0]               addr_q, addr_n;
    logic [31:0]               wdata_q, wdata_n;
    logic [BYTES_PER_WORD-1:0] en_q, en_n;
    logic [1:0]                idx_q, idx_n;
    logic                      err_q;
    logic                      ready;
    logic                      accept;
    logic                      capture;
    logic                      timeout_hit;
    logic                      expired;
    bm_next_t                  first, rest;

    bm_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ISSUE),
        .enable  (state == ISSUE),
        .expired (expired)
    );

    // A lingering resp from the previous byte must settle before a new word starts.
    assign ready         = (state == IDLE) && !bus.mem_resp;
    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_err   = (state == DONE) && err_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_n     = state;
        op_n        = op_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        en_n        = en_q;
        idx_n       = idx_q;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        first       = next_enabled(bus.req_read ? 4'hF : bus.req_wmask, 3'd0);
        rest        = next_enabled(en_q, {1'b0, idx_q} + 3'd1);

        case (state)
            IDLE: begin
                if (ready && (bus.req_read || bus.req_write)) begin
                    accept  = 1'b1;
                    op_n    = bus.req_read ? READ : WRITE;
                    addr_n  = bus.req_addr & 32'hFFFF_FFFC;
                    wdata_n = bus.req_wdata;
                    en_n    = bus.req_read ? 4'hF : bus.req_wmask;
                    idx_n   = first.idx;
                    state_n = first.valid ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (bus.mem_resp) begin
                    capture = (op_q == READ);
                    state_n = rest.valid ? GAP : DONE;
                end else if (expired) begin
                    timeout_hit = 1'b1;
                    state_n     = DONE;
                end
            end
            GAP: begin
                if (!bus.mem_resp) begin
                    idx_n   = rest.idx;
                    state_n = ISSUE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Strobe, address and write byte are registered from the next state so
    // they stay constant for the whole ISSUE stay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= READ;
            addr_q        <= '0;
            wdata_q       <= '0;
            en_q          <= '0;
            idx_q         <= '0;
            err_q         <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            op_q    <= op_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            en_q    <= en_n;
            idx_q   <= idx_n;

            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end

            if (accept) begin
                bus.rsp_rdata <= '0;
            end else if (capture) begin
                bus.rsp_rdata[8*idx_q +: 8] <= bus.mem_rdata;
            end

            bus.mem_read  <= (state_n == ISSUE) && (op_n == READ);
            bus.mem_write <= (state_n == ISSUE) && (op_n == WRITE);
            bus.mem_addr  <= (state_n == ISSUE) ? addr_n + 32'(idx_n) : '0;
            bus.mem_wdata <= ((state_n == ISSUE) && (op_n == WRITE)) ? wdata_n[8*idx_n +: 8] : '0;
        end
    end

    a_one_strobe: assert property (@(posedge clk) disable iff (rst)
        !(bus.mem_read && bus.mem_write));

    a_rsp_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.rsp_valid |=> !bus.rsp_valid);

    a_issue_stable: assert property (@(posedge clk) disable iff (rst)
        (state == ISSUE && state_n == ISSUE) |=> $stable(bus.mem_addr) && (bus.mem_read || bus.mem_write));

endmodule

// File: tb/tb_byte_mem_initiator.sv
// Directed bench for byte_mem_initiator against a pulse-acknowledge byte memory.
module tb_byte_mem_initiator;

    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    byte_mem_initiator_if bus ();

    byte_mem_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Responder: acks one cycle after sampling a strobe, with a single-cycle resp pulse.
    logic [7:0]  mem [0:4095];
    logic        poke_en;
    logic [11:0] poke_addr;
    logic [7:0]  poke_data;
    logic        stall_en;
    logic [31:0] stall_addr;
    logic [31:0] addr_log [$];
    int          strobe_cnt = 0;
    int          stall_cnt  = 0;
    int          valid_cnt  = 0;
    wire         strobe = bus.mem_read | bus.mem_write;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_resp  <= 1'b0;
            bus.mem_rdata <= 8'h00;
        end else begin
            if (poke_en) mem[poke_addr] <= poke_data;
            if (strobe && !bus.mem_resp && !(stall_en && bus.mem_addr == stall_addr)) begin
                bus.mem_resp <= 1'b1;
                if (bus.mem_write) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
                else               bus.mem_rdata <= mem[bus.mem_addr[11:0]];
                addr_log.push_back(bus.mem_addr);
            end else begin
                bus.mem_resp <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (strobe) strobe_cnt <= strobe_cnt + 1;
        if (strobe && stall_en && bus.mem_addr == stall_addr) stall_cnt <= stall_cnt + 1;
        if (bus.rsp_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int lat, output logic [31:0] rdata, output logic err);
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat   = n;
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                break;
            end
        end
        check({tag, "_rsp_seen"}, 32'(lat != 0), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m,
                          output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_wmask = m;
        @(posedge clk);
        #1;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        wait_rsp(tag, lat, rdata, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int          lat, lat2, base, snap;
        logic [31:0] rdata;
        logic        err;
        int          ready_hi;

        rst           = 1'b1;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        poke_en       = 1'b0;
        poke_addr     = '0;
        poke_data     = '0;
        stall_en      = 1'b0;
        stall_addr    = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_err",   32'(bus.rsp_err),   32'd0);
        check("rst_rdata", bus.rsp_rdata,      32'd0);
        check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_maddr", bus.mem_addr,       32'd0);
        check("rst_mwdata", 32'(bus.mem_wdata), 32'd0);
        rst = 1'b0;

        poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
        poke(12'h204, 8'hA0); poke(12'h205, 8'hA1); poke(12'h206, 8'hA2); poke(12'h207, 8'hA3);
        poke(12'h301, 8'h51); poke(12'h302, 8'h52); poke(12'h303, 8'h53);
        poke(12'h400, 8'h11); poke(12'h401, 8'h22); poke(12'h402, 8'h33); poke(12'h403, 8'h44);

        // Full word read
        base = addr_log.size();
        do_req("rd100", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 4'h0, lat, rdata, err);
        check("rd100_lat",   32'(lat), 32'd12);
        check("rd100_rdata", rdata,    32'h4433_2211);
        check("rd100_err",   32'(err), 32'd0);
        check("rd100_nacc",  32'(addr_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("rd100_addr%0d", i), addr_log[base+i], 32'h100 + 32'(i));

        // Empty mask: no strobe, immediate completion, rdata cleared
        snap = strobe_cnt;
        do_req("wr_m0", 1'b0, 1'b1, 32'h0000_0600, 32'hFFFF_FFFF, 4'b0000, lat, rdata, err);
        check("wr_m0_lat",     32'(lat), 32'd1);
        check("wr_m0_rdata",   rdata,    32'd0);
        check("wr_m0_strobes", 32'(strobe_cnt - snap), 32'd0);

        // Sparse mask 1010
        base = addr_log.size();
        do_req("wr_m1010", 1'b0, 1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 4'b1010, lat, rdata, err);
        check("wr_m1010_lat",   32'(lat), 32'd6);
        check("wr_m1010_mem",   {mem[12'h207], mem[12'h206], mem[12'h205], mem[12'h204]}, 32'hDEA2_BEA0);
        check("wr_m1010_nacc",  32'(addr_log.size() - base), 32'd2);
        check("wr_m1010_addr0", addr_log[base],   32'h205);
        check("wr_m1010_addr1", addr_log[base+1], 32'h207);
        check("wr_m1010_rdata", rdata, 32'd0);

        // Single byte write
        do_req("wr_m0100", 1'b0, 1'b1, 32'h0000_0300, 32'h12AB_3456, 4'b0100, lat, rdata, err);
        check("wr_m0100_lat", 32'(lat), 32'd3);
        check("wr_m0100_mem", {8'h00, mem[12'h303], mem[12'h302], mem[12'h301]}, 32'h0053_AB51);

        // Timeout on byte 2
        stall_en   = 1'b1;
        stall_addr = 32'h402;
        snap       = stall_cnt;
        do_req("tmo", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, lat, rdata, err);
        check("tmo_strobe_cycles", 32'(stall_cnt - snap), 32'(TIMEOUT + 1));
        check("tmo_lat",   32'(lat), 32'd16);
        check("tmo_err",   32'(err), 32'd1);
        check("tmo_rdata", rdata,    32'h0000_2211);
        stall_en = 1'b0;

        // Reset during ISSUE of byte 1
        @(negedge clk);
        bus.req_read = 1'b1;
        bus.req_addr = 32'h0000_0100;
        @(posedge clk);
        #1 bus.req_read = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_strobe", 32'(bus.mem_read), 32'd1);
        check("mid_addr",   bus.mem_addr,      32'h101);
        snap = valid_cnt;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("mid_rst_addr",    bus.mem_addr,       32'd0);
        check("mid_rst_valid",   32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rdata",   bus.rsp_rdata,      32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_valid", 32'(valid_cnt - snap), 32'd0);
        do_req("post_rst", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, lat, rdata, err);
        check("post_rst_lat",   32'(lat), 32'd12);
        check("post_rst_rdata", rdata,    32'h4433_2211);

        // Read+write together, with a second request held pending
        @(negedge clk);
        bus.req_read  = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0100;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.req_wmask = 4'hF;
        @(posedge clk);
        #1;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0500;
        bus.req_wdata = 32'h0000_0077;
        bus.req_wmask = 4'b0001;
        ready_hi = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.req_ready) ready_hi++;
            if (n == 12) begin
                check("b2b_valid", 32'(bus.rsp_valid), 32'd1);
                check("b2b_rdata", bus.rsp_rdata,      32'h4433_2211);
                check("b2b_err",   32'(bus.rsp_err),   32'd0);
            end
        end
        check("b2b_ready_low", 32'(ready_hi), 32'd0);
        @(negedge clk);
        check("b2b_ready_after_done", 32'(bus.req_ready), 32'd1);
        check("b2b_resp_low",         32'(bus.mem_resp),  32'd0);
        @(posedge clk);
        #1 bus.req_write = 1'b0;
        wait_rsp("b2b2", lat2, rdata, err);
        check("b2b2_lat",    32'(lat2), 32'd3);
        check("b2b2_mem",    32'(mem[12'h500]), 32'h77);
        check("b2b_no_write", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'h4433_2211);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
